coproc_issuer: RTL and testbench
================================

Name: coproc_issuer

Overview:
- Host-side initiator for the matrix coprocessor control unit.
- Accepts a 5-bit instruction and a byte stream of matrix elements from the HPS bridge, and packs the elements into the two 200-bit operand buses.
- Drives start with a handshake against the coprocessor's ready, then streams the result bytes back to the host with an overflow/error status.
- Runs on the fast clock; the coprocessor runs on its internally divided clock.

Parameters:
- TIMEOUT, 4096: clk cycles allowed per coprocessor handshake phase before a timeout error.
- SYNC_STAGES, 2: flip-flop stages on the cp_ready and cp_overflow inputs.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  host presents instruction
- cmd_instr  input  5  {opcode[4:2], size[1:0]}; size 00=2x2, 01=3x3, 10=4x4, 11=5x5
- cmd_ready  output  1  high only in IDLE
- in_valid  input  1  element byte valid
- in_data  input  8  signed element, row-major
- in_ready  output  1  high in LOAD_A/LOAD_B
- cp_matrix1  output  200  operand A to coprocessor
- cp_matrix2  output  200  operand B to coprocessor
- cp_instruction  output  5  latched instruction
- cp_start  output  1  start request
- cp_result  input  200  coprocessor result
- cp_ready  input  1  coprocessor ready
- cp_overflow  input  1  coprocessor overflow
- out_valid  output  1  result byte valid
- out_data  output  8  result byte
- out_last  output  1  final result byte
- out_ready  input  1  host accepts byte
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of operation
- ovf_flag  output  1  latched overflow of last op
- err_flag  output  1  latched timeout or illegal opcode

Behaviour:
- Reset: state=IDLE; cp_matrix1, cp_matrix2, cp_instruction, out_data = 0; cp_start, out_valid, out_last, done, ovf_flag, err_flag, busy = 0; cmd_ready=1; in_ready=0; counters and sync flops 0.
- Derived values: N = size+2; E = N*N.
- Packing: element k (0..E-1) goes to bits [199-8k -: 8]; unused bytes stay 0.
- Element counts per opcode:
  - 000 add, 001 sub, 010 matrix mult: E bytes into A, then E bytes into B.
  - 011 scalar mult: E bytes into A, then 1 byte into cp_matrix2[7:0].
  - 100 det, 101 transpose, 110 opposite: E bytes into A only; B = 0.
- IDLE:
  - On cmd_valid, latch cmd_instr, clear both operand buses, and clear ovf_flag and err_flag.
  - Opcode 111: set err_flag, pulse done next cycle, stay in IDLE; no load, no start.
  - Otherwise go to LOAD_A.
- LOAD_A / LOAD_B:
  - A byte is accepted on in_valid & in_ready. The index counter increments; on the last byte, move to the next state on the following edge.
  - in_valid low stalls with no timeout.
- ISSUE: assert cp_start; move to WAIT_ACK.
- WAIT_ACK:
  - Hold cp_start=1 until synced cp_ready=0, then drop cp_start and go to WAIT_DONE.
  - If TIMEOUT cycles elapse, set err_flag, drop cp_start, and go to FINISH.
- WAIT_DONE:
  - On synced cp_ready rising to 1, capture cp_result into a 200-bit result register, set ovf_flag = synced cp_overflow, and go to DRAIN.
  - If TIMEOUT cycles elapse, set err_flag and go to FINISH.
- DRAIN:
  - Bytes stream MSB-first: byte j = result[199-8j -: 8], j = 0..E-1.
  - Determinant emits exactly one byte, result[7:0].
  - out_valid is held until out_ready; out_data is stable while valid & !ready.
  - out_last is high with the final byte. After the last transfer, go to FINISH.
- FINISH: pulse done for one cycle; go to IDLE.
- cp_start must never be reasserted before cp_ready has been seen low then high, so one command yields exactly one coprocessor operation despite the clock ratio.
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- Simultaneous events:
  - cmd_valid in the reset-release cycle is not accepted.
  - A timeout and a ready edge in the same cycle resolve as ready wins.
- Reset mid-operation: all state returns to reset values immediately, and cp_start drops asynchronously.

Test Plan:
- 2x2 add (instr 00000), A=1,2,3,4, B=10,20,30,40 -> cp_matrix1[199:168]=01020304h; one start handshake; out bytes 11,22,33,44; last byte has out_last; ovf_flag=0; one done pulse.
- 5x5 scalar mult (01111), A = all 100, scalar 2 -> cp_matrix2[7:0]=02h; 25 bytes out; ovf_flag=1 after the coprocessor reports overflow.
- 3x3 det (10001), A=[2,0,0;0,3,0;0,0,4] -> only 9 bytes consumed; exactly 1 out byte = 24 (18h) with out_last=1.
- Backpressure: out_ready toggled 1/0 every cycle during a 4x4 transpose -> 16 bytes, no duplicates or drops, out_data stable while stalled.
- Coprocessor model holds cp_ready=1 forever -> after TIMEOUT cycles, err_flag=1, cp_start=0, done pulse, return to IDLE; opcode 111 -> err_flag=1 with no cp_start.
- Reset asserted in WAIT_DONE -> cp_start=0, busy=0, cmd_ready=1 asynchronously; next command completes normally.

Source files
------------

// File: rtl/coproc_issuer.sv
// -----------------------------------------------------------------------------
// coproc_issuer
//
// Host-side initiator for the matrix coprocessor. A 5-bit instruction and a
// row-major byte stream of signed elements arrive from the host bridge. The
// bytes are packed into two 200-bit operand buses, one start handshake is run
// against the coprocessor's ready line, and the result is then streamed back
// to the host one byte at a time with overflow / error status.
//
// Ports:
//   clk, rst          fast system clock, asynchronous active-high reset
//   cmd_valid/ready   instruction handshake; cmd_instr = {opcode[4:2], size[1:0]}
//   in_valid/ready    element byte handshake, in_data = signed element
//   cp_matrix1/2      operand A / B buses to the coprocessor (element k at [199-8k -: 8])
//   cp_instruction    latched instruction
//   cp_start          start request, held until the coprocessor drops ready
//   cp_result         coprocessor result bus (captured when ready returns)
//   cp_ready          coprocessor ready (other clock domain, synchronised here)
//   cp_overflow       coprocessor overflow (other clock domain, synchronised here)
//   out_valid/ready   result byte handshake, out_data MSB-first, out_last on final byte
//   busy              high whenever not idle
//   done              one-cycle pulse at the end of every operation
//   ovf_flag          overflow of the last operation
//   err_flag          timeout or illegal opcode on the last operation
// -----------------------------------------------------------------------------
module coproc_issuer #(
   parameter int TIMEOUT     = 4096,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   input  logic [4:0]   cmd_instr,
   output logic         cmd_ready,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic [199:0] cp_matrix1,
   output logic [199:0] cp_matrix2,
   output logic [4:0]   cp_instruction,
   output logic         cp_start,
   input  logic [199:0] cp_result,
   input  logic         cp_ready,
   input  logic         cp_overflow,
   output logic         out_valid,
   output logic [7:0]   out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         done,
   output logic         ovf_flag,
   output logic         err_flag
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int NB = 25;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t                 state_q, state_d;
   logic [4:0]             instr_q;
   logic                   armed_q;
   logic [4:0]             idx_q, idx_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [199:0]           result_q;
   logic                   ovf_q, err_q;
   logic                   done_q, done_d;
   logic                   cp_start_q, cp_start_d;
   logic [SYNC_STAGES-1:0] rdy_sync_q, ovf_sync_q;
   logic                   rdy_s, ovf_s;

   logic [7:0]             a_lane_q [NB];
   logic [7:0]             b_lane_q [NB];
   logic [7:0]             res_lane [NB];
   logic [NB-1:0]          a_wr, b_wr;

   logic [2:0]             opcode;
   logic [4:0]             elem_cnt, a_last, b_last, out_last_idx, b_sel, out_sel;
   logic                   accept, illegal, capture, timeout;

   // ---------------------------------------------------------------------
   // Instruction decode
   // ---------------------------------------------------------------------
   assign opcode = instr_q[4:2];

   always_comb begin
      elem_cnt = 5'd25;
      case (instr_q[1:0])
         2'b00:   elem_cnt = 5'd4;
         2'b01:   elem_cnt = 5'd9;
         2'b10:   elem_cnt = 5'd16;
         default: elem_cnt = 5'd25;
      endcase
   end

   assign a_last       = elem_cnt - 5'd1;
   // Scalar multiply takes a single B byte, which lands in the last lane ([7:0]).
   assign b_last       = (opcode == 3'b011) ? 5'd0  : a_last;
   assign b_sel        = (opcode == 3'b011) ? 5'd24 : idx_q;
   // Determinant returns a single byte taken from the last lane ([7:0]).
   assign out_last_idx = (opcode == 3'b100) ? 5'd0  : a_last;
   assign out_sel      = (opcode == 3'b100) ? 5'd24 : idx_q;

   // armed_q blocks acceptance on the first edge after reset release.
   assign accept  = (state_q == S_IDLE) && cmd_valid && armed_q;
   assign illegal = accept && (cmd_instr[4:2] == 3'b111);

   // ---------------------------------------------------------------------
   // Byte lanes: write enables, operand packing and result unpacking
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         assign a_wr[gi] = (state_q == S_LOAD_A) && in_valid && (idx_q == 5'(gi));
         assign b_wr[gi] = (state_q == S_LOAD_B) && in_valid && (b_sel == 5'(gi));
         assign cp_matrix1[199-8*gi -: 8] = a_lane_q[gi];
         assign cp_matrix2[199-8*gi -: 8] = b_lane_q[gi];
         assign res_lane[gi]              = result_q[199-8*gi -: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            a_lane_q[i] <= 8'h00;
            b_lane_q[i] <= 8'h00;
         end
      end else if (accept) begin
         for (int i = 0; i < NB; i++) begin
            a_lane_q[i] <= 8'h00;
            b_lane_q[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (a_wr[i]) a_lane_q[i] <= in_data;
            if (b_wr[i]) b_lane_q[i] <= in_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Synchronisers for the coprocessor-domain status lines
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_sync_q <= '0;
         ovf_sync_q <= '0;
      end else begin
         rdy_sync_q[0] <= cp_ready;
         ovf_sync_q[0] <= cp_overflow;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rdy_sync_q[i] <= rdy_sync_q[i-1];
            ovf_sync_q[i] <= ovf_sync_q[i-1];
         end
      end
   end

   assign rdy_s = rdy_sync_q[SYNC_STAGES-1];
   assign ovf_s = ovf_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      capture = 1'b0;
      timeout = 1'b0;

      case (state_q)
         S_IDLE: begin
            idx_d = 5'd0;
            tmo_d = '0;
            if (accept && !illegal) state_d = S_LOAD_A;
         end

         S_LOAD_A: begin
            if (in_valid) begin
               if (idx_q == a_last) begin
                  idx_d   = 5'd0;
                  // Opcodes 0xx carry a B operand; det/transpose/opposite do not.
                  state_d = opcode[2] ? S_ISSUE : S_LOAD_B;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end

         S_LOAD_B: begin
            if (in_valid) begin
               if (idx_q == b_last) begin
                  idx_d   = 5'd0;
                  state_d = S_ISSUE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end

         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT_ACK;
         end

         // The coprocessor acknowledges start by dropping ready.
         S_WAIT_ACK: begin
            if (!rdy_s) begin
               tmo_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = S_FINISH;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         // Ready was low on entry, so a high level here is the rising edge.
         // Checked before the timeout so a coincident ready wins.
         S_WAIT_DONE: begin
            if (rdy_s) begin
               capture = 1'b1;
               idx_d   = 5'd0;
               state_d = S_DRAIN;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = S_FINISH;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_DRAIN: begin
            if (out_ready) begin
               if (idx_q == out_last_idx) begin
                  idx_d   = 5'd0;
                  state_d = S_FINISH;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered so start is glitch-free toward the slower domain.
      cp_start_d = (state_d == S_ISSUE) || (state_d == S_WAIT_ACK);
      done_d     = (state_d == S_FINISH) || illegal;
   end

   // ---------------------------------------------------------------------
   // State and status registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         instr_q    <= 5'd0;
         armed_q    <= 1'b0;
         idx_q      <= 5'd0;
         tmo_q      <= '0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         cp_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= 1'b1;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         done_q     <= done_d;
         cp_start_q <= cp_start_d;

         if (accept) begin
            instr_q <= cmd_instr;
            ovf_q   <= 1'b0;
            err_q   <= illegal;
         end
         if (timeout) err_q <= 1'b1;
         if (capture) begin
            result_q <= cp_result;
            ovf_q    <= ovf_s;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign cmd_ready      = (state_q == S_IDLE);
   assign in_ready       = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign busy           = (state_q != S_IDLE);
   assign cp_instruction = instr_q;
   assign cp_start       = cp_start_q;
   assign done           = done_q;
   assign ovf_flag       = ovf_q;
   assign err_flag       = err_q;

   // out_data only moves when idx_q advances on an accepted byte, so it is
   // stable while the host stalls.
   assign out_valid = (state_q == S_DRAIN);
   assign out_data  = out_valid ? res_lane[out_sel] : 8'h00;
   assign out_last  = out_valid && (idx_q == out_last_idx);

endmodule

// File: tb/tb_coproc_issuer.sv
module tb_coproc_issuer;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic [4:0]   cmd_instr;
   logic         cmd_ready;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic [199:0] cp_matrix1, cp_matrix2;
   logic [4:0]   cp_instruction;
   logic         cp_start;
   logic [199:0] cp_result;
   logic         cp_ready;
   logic         cp_overflow;
   logic         out_valid;
   logic [7:0]   out_data;
   logic         out_last;
   logic         out_ready;
   logic         busy, done, ovf_flag, err_flag;

   always #5 clk = ~clk;

   coproc_issuer dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_instr      (cmd_instr),
      .cmd_ready      (cmd_ready),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .cp_matrix1     (cp_matrix1),
      .cp_matrix2     (cp_matrix2),
      .cp_instruction (cp_instruction),
      .cp_start       (cp_start),
      .cp_result      (cp_result),
      .cp_ready       (cp_ready),
      .cp_overflow    (cp_overflow),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_last       (out_last),
      .out_ready      (out_ready),
      .busy           (busy),
      .done           (done),
      .ovf_flag       (ovf_flag),
      .err_flag       (err_flag)
   );

   int           n_vec = 0;
   int           n_err = 0;
   int           done_cnt = 0;
   int           start_cnt = 0;
   logic [8:0]   exp_q[$];
   logic [7:0]   a_vec [25];
   logic [7:0]   b_vec [25];
   bit           toggle_mode = 1'b0;
   bit           stuck_ready = 1'b0;
   int           done_delay = 6;
   logic [199:0] staged_res = '0;
   logic         staged_ovf = 1'b0;
   logic [199:0] cap_m1 = '0;
   logic [199:0] cap_m2 = '0;
   logic [4:0]   cap_instr = '0;

   task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail_wait(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait expired, required event never seen", name);
   endtask

   task automatic push(input logic last, input logic [7:0] d);
      exp_q.push_back({last, d});
   endtask

   // Coprocessor model: acknowledges start by dropping ready, then after
   // done_delay cycles presents the staged result and raises ready again.
   initial begin
      int cnt;
      int mstate;
      cnt = 0;
      mstate = 0;
      cp_ready = 1'b1;
      cp_overflow = 1'b0;
      cp_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (stuck_ready) begin
            cp_ready = 1'b1;
            mstate = 0;
         end else begin
            case (mstate)
               0: if (cp_start) begin
                     cap_m1 = cp_matrix1;
                     cap_m2 = cp_matrix2;
                     cap_instr = cp_instruction;
                     cnt = 0;
                     mstate = 1;
                  end
               1: begin
                     cnt++;
                     if (cnt == 3) begin
                        cp_ready = 1'b0;
                        mstate = 2;
                     end
                  end
               2: if (!cp_start) begin
                     cnt = 0;
                     mstate = 3;
                  end
               3: begin
                     cnt++;
                     if (cnt >= done_delay) begin
                        cp_result = staged_res;
                        cp_overflow = staged_ovf;
                        cp_ready = 1'b1;
                        mstate = 0;
                     end
                  end
               default: mstate = 0;
            endcase
         end
      end
   end

   // Host sink: always ready, or toggling 1/0 every cycle.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = toggle_mode ? ~out_ready : 1'b1;
      end
   end

   // Monitor: scoreboard pops, stall stability, done and start counting.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       prev_start;
      logic [8:0] e;
      prev_stall = 1'b0;
      prev_data = 8'h00;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (prev_stall) begin
               chk_v("stall_valid", 32'(out_valid), 32'd1);
               chk_v("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
               $display("out byte %02h last=%0b", out_data, out_last);
               if (exp_q.size() == 0) begin
                  fail_wait("unexpected_out_byte");
               end else begin
                  e = exp_q.pop_front();
                  chk_v("out_byte", 32'({out_last, out_data}), 32'(e));
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (done) done_cnt++;
            if (cp_start && !prev_start) start_cnt++;
            prev_start = cp_start;
         end
      end
   end

   task automatic send_cmd(input logic [4:0] instr);
      int g;
      g = 0;
      while (!cmd_ready && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 100) fail_wait("cmd_ready");
      cmd_instr = instr;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic feed(input int na, input int nb, input bit gap);
      int g;
      for (int k = 0; k < na + nb; k++) begin
         if (gap && k == 2) begin
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
         end
         in_data = (k < na) ? a_vec[k] : b_vec[k-na];
         in_valid = 1'b1;
         g = 0;
         while (!in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
         end
         if (g >= 100) begin
            fail_wait("in_ready");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk_v("in_ready_after_load", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_done(input int d0);
      int g;
      g = 0;
      while (done_cnt == d0 && g < 6000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 6000) fail_wait("done");
   endtask

   task automatic post(input string name, input logic exp_ovf, input logic exp_err,
                       input int s0, input int d0);
      chk_v({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk_v({name, "_starts"}, 32'(start_cnt - s0), 32'd1);
      chk_v({name, "_ovf"}, 32'(ovf_flag), 32'(exp_ovf));
      chk_v({name, "_err"}, 32'(err_flag), 32'(exp_err));
      chk_v({name, "_busy"}, 32'(busy), 32'd0);
      chk_v({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk_v({name, "_cp_start"}, 32'(cp_start), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk_v({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      $display("op %s complete", name);
   endtask

   initial begin
      int s0, d0;
      int tr [16];
      tr = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0;
      int tr [16];
      tr = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_instr = 5'd0;
      in_valid = 1'b0;
      in_data = 8'h00;
      for (int k = 0; k < 25; k++) begin
         a_vec[k] = 8'h00;
         b_vec[k] = 8'h00;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_v("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk_v("rst_in_ready", 32'(in_ready), 32'd0);
      chk_v("rst_busy", 32'(busy), 32'd0);
      chk_v("rst_cp_start", 32'(cp_start), 32'd0);
      chk_v("rst_out_valid", 32'(out_valid), 32'd0);
      chk_v("rst_out_last", 32'(out_last), 32'd0);
      chk_v("rst_out_data", 32'(out_data), 32'd0);
      chk_v("rst_done", 32'(done), 32'd0);
      chk_v("rst_flags", 32'({ovf_flag, err_flag}), 32'd0);
      chk_v("rst_instr", 32'(cp_instruction), 32'd0);
      chk_w("rst_matrix1", cp_matrix1, 200'd0);
      chk_w("rst_matrix2", cp_matrix2, 200'd0);

      // cmd_valid held across reset release is not taken on the first edge
      cmd_instr = 5'b00000;
      cmd_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk_v("release_not_accepted", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // 2x2 add, with a stall gap on the input stream
      a_vec[0] = 8'd1;  a_vec[1] = 8'd2;  a_vec[2] = 8'd3;  a_vec[3] = 8'd4;
      b_vec[0] = 8'd10; b_vec[1] = 8'd20; b_vec[2] = 8'd30; b_vec[3] = 8'd40;
      staged_res = {32'h0B16212C, 168'h0};
      staged_ovf = 1'b0;
      push(1'b0, 8'd11); push(1'b0, 8'd22); push(1'b0, 8'd33); push(1'b1, 8'd44);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b00000);
      feed(4, 4, 1'b1);
      wait_done(d0);
      post("add2x2", 1'b0, 1'b0, s0, d0);
      chk_w("add_m1", cap_m1, {32'h01020304, 168'h0});
      chk_w("add_m2", cap_m2, {32'h0A141E28, 168'h0});
      chk_v("add_instr", 32'(cap_instr), 32'h00);

      // 5x5 scalar multiply with overflow
      for (int k = 0; k < 25; k++) a_vec[k] = 8'd100;
      b_vec[0] = 8'd2;
      staged_res = {25{8'hC8}};
      staged_ovf = 1'b1;
      for (int k = 0; k < 25; k++) push(k == 24, 8'hC8);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b01111);
      feed(25, 1, 1'b0);
      wait_done(d0);
      post("smul5x5", 1'b1, 1'b0, s0, d0);
      chk_w("smul_m1", cap_m1, {25{8'h64}});
      chk_w("smul_m2", cap_m2, 200'h02);
      chk_v("smul_instr", 32'(cap_instr), 32'h0F);

      // 3x3 determinant: 9 bytes in, one byte out taken from [7:0]
      for (int k = 0; k < 25; k++) a_vec[k] = 8'h00;
      a_vec[0] = 8'd2; a_vec[4] = 8'd3; a_vec[8] = 8'd4;
      staged_res = {{24{8'hA5}}, 8'h18};
      staged_ovf = 1'b0;
      push(1'b1, 8'h18);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b10001);
      feed(9, 0, 1'b0);
      wait_done(d0);
      post("det3x3", 1'b0, 1'b0, s0, d0);
      chk_w("det_m1", cap_m1, {72'h020000000300000004, 128'h0});
      chk_w("det_m2", cap_m2, 200'd0);

      // 4x4 transpose with out_ready toggling every cycle
      for (int k = 0; k < 16; k++) a_vec[k] = 8'(k + 1);
      staged_res = {128'h0105090D02060A0E03070B0F04080C10, 72'hAAAAAAAAAAAAAAAAAA};
      staged_ovf = 1'b0;
      for (int k = 0; k < 16; k++) push(k == 15, 8'(tr[k]));
      toggle_mode = 1'b1;
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b10110);
      feed(16, 0, 1'b0);
      wait_done(d0);
      toggle_mode = 1'b0;
      post("trans4x4", 1'b0, 1'b0, s0, d0);
      chk_w("trans_m1", cap_m1, {128'h0102030405060708090A0B0C0D0E0F10, 72'h0});

      // Coprocessor never drops ready: handshake times out
      stuck_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_vec[k] = 8'(k + 1);
         b_vec[k] = 8'(k + 5);
      end
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b00000);
      feed(4, 4, 1'b0);
      wait_done(d0);
      post("timeout", 1'b0, 1'b1, s0, d0);
      stuck_ready = 1'b0;

      // Illegal opcode: error, done pulse, no load and no start
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b11100);
      chk_v("illegal_done", 32'(done), 32'd1);
      chk_v("illegal_err", 32'(err_flag), 32'd1);
      chk_v("illegal_busy", 32'(busy), 32'd0);
      chk_v("illegal_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk_v("illegal_done_drop", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk_v("illegal_no_start", 32'(start_cnt - s0), 32'd0);
      chk_v("illegal_one_done", 32'(done_cnt - d0), 32'd1);
      $display("op illegal complete");

      // Reset asserted mid-operation while waiting for the result
      done_delay = 40;
      for (int k = 0; k < 4; k++) begin
         a_vec[k] = 8'(k + 5);
         b_vec[k] = 8'd1;
      end
      send_cmd(5'b00100);
      feed(4, 4, 1'b0);
      begin
         int g;
         g = 0;
         while (cp_start && g < 200) begin
            @(posedge clk);
            #1;
            g++;
         end
         if (g >= 200) fail_wait("cp_start_drop");
      end
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_v("midrst_cp_start", 32'(cp_start), 32'd0);
      chk_v("midrst_busy", 32'(busy), 32'd0);
      chk_v("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      $display("op midreset complete");
      repeat (60) @(posedge clk);
      #1;
      done_delay = 6;

      // Normal operation after reset: 2x2 subtract
      a_vec[0] = 8'd9; a_vec[1] = 8'd8; a_vec[2] = 8'd7; a_vec[3] = 8'd6;
      b_vec[0] = 8'd1; b_vec[1] = 8'd2; b_vec[2] = 8'd3; b_vec[3] = 8'd4;
      staged_res = {32'h08060402, 168'h0};
      staged_ovf = 1'b0;
      push(1'b0, 8'd8); push(1'b0, 8'd6); push(1'b0, 8'd4); push(1'b1, 8'd2);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd(5'b00100);
      feed(4, 4, 1'b0);
      wait_done(d0);
      post("sub_after_reset", 1'b0, 1'b0, s0, d0);
      chk_w("sub_m1", cap_m1, {32'h09080706, 168'h0});
      chk_w("sub_m2", cap_m2, {32'h01020304, 168'h0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
